// File: rtl/hash_mem_pkg.sv
// Shared types and helpers for the hash-core memory responder.
// Address decode is a 17-bit compare so an upper bound past 16'hFFFF saturates instead of wrapping.
package hash_mem_pkg;

    typedef logic [31:0] word_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLEAR      = 2'd1,
        CLEAR_HOLD = 2'd2
    } clr_state_t;

    localparam word_t OOB_DATA_DEFAULT = 32'hDEADBEEF;

    function automatic logic addr_hit(input addr_t addr, input addr_t base, input logic [16:0] depth);
        logic [16:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < depth);
    endfunction

endpackage

// File: rtl/spram_1p.sv
// Single-port DEPTH x 32 RAM, registered read, write-first (a write also drives the read register).
module spram_1p
    import hash_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  word_t         wdata_i,
    output word_t         rdata_o
);

    word_t mem_q [DEPTH];
    word_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hash_mem_responder.sv
// Memory-side responder: core port (absolute priority), host preload/readback port,
// sequential clear engine, saturating core access counters and sticky out-of-range flag.
module hash_mem_responder
    import hash_mem_pkg::*;
#(
    parameter int    DEPTH     = 256,
    parameter addr_t BASE_ADDR = 16'h0000,
    parameter word_t OOB_DATA  = OOB_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_en,
    input  logic        mem_clk,
    input  logic        mem_we,
    input  logic [15:0] memory_addr,
    input  logic [31:0] memory_write_data,
    output logic [31:0] memory_read_data,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_ready,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    input  logic        clear,
    output logic        clear_busy,
    output logic        oob_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt,
    output clr_state_t  dbg_clr_state
);

    localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0]  DEPTH17 = 17'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    clr_state_t    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          oob_q, oob_d;
    logic [15:0]   rd_cnt_q, wr_cnt_q;
    logic          core_rd_q, core_oob_q;
    logic          host_rv_q, host_oob_q;
    word_t         mrd_hold_q, hrd_hold_q;

    logic          core_hit, host_hit;
    addr_t         core_off, host_off;
    logic          core_rd, core_wr, host_acc;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    word_t         ram_wdata, ram_rdata;

    assign core_hit = addr_hit(memory_addr, BASE_ADDR, DEPTH17);
    assign host_hit = addr_hit(host_addr, BASE_ADDR, DEPTH17);
    assign core_off = memory_addr - BASE_ADDR;
    assign host_off = host_addr - BASE_ADDR;

    // mem_clk is the same net as clk by contract; only its presence is acknowledged.
    logic unused_sig;
    assign unused_sig = ^{mem_clk, core_off, host_off};

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        oob_d      = oob_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        host_ready = 1'b0;
        host_acc   = 1'b0;
        core_rd    = 1'b0;
        core_wr    = 1'b0;
        if (!reset) begin
            if (core_en) begin
                core_rd   = !mem_we;
                core_wr   = mem_we;
                ram_en    = core_hit;
                ram_we    = mem_we;
                ram_addr  = core_off[AW-1:0];
                ram_wdata = memory_write_data;
                if (!core_hit) oob_d = 1'b1;
            end else if (state_q != IDLE) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = ptr_q;
            end else if (host_req) begin
                host_ready = 1'b1;
                host_acc   = 1'b1;
                ram_en     = host_hit;
                ram_we     = host_we;
                ram_addr   = host_off[AW-1:0];
                ram_wdata  = host_wdata;
                if (!host_hit) oob_d = 1'b1;
            end

            // A cycle with core_en low always zeroes one word, even the one leaving CLEAR_HOLD.
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        state_d = CLEAR;
                        ptr_d   = '0;
                    end
                end
                CLEAR, CLEAR_HOLD: begin
                    if (core_en) begin
                        state_d = CLEAR_HOLD;
                    end else if (ptr_q == LAST_PTR) begin
                        state_d = IDLE;
                    end else begin
                        state_d = CLEAR;
                        ptr_d   = ptr_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            oob_q      <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            core_rd_q  <= 1'b0;
            core_oob_q <= 1'b0;
            host_rv_q  <= 1'b0;
            host_oob_q <= 1'b0;
            mrd_hold_q <= '0;
            hrd_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            oob_q      <= oob_d;
            core_rd_q  <= core_rd;
            core_oob_q <= !core_hit;
            host_rv_q  <= host_acc && !host_we;
            host_oob_q <= !host_hit;
            mrd_hold_q <= memory_read_data;
            hrd_hold_q <= host_rdata;
            if (core_rd && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (core_wr && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    spram_1p #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // The shared RAM read register is only shown to a port right after that port's read.
    assign memory_read_data = core_rd_q ? (core_oob_q ? OOB_DATA : ram_rdata) : mrd_hold_q;
    assign host_rdata       = host_rv_q ? (host_oob_q ? OOB_DATA : ram_rdata) : hrd_hold_q;
    assign host_rvalid      = host_rv_q;
    assign clear_busy       = (state_q != IDLE);
    assign oob_err          = oob_q;
    assign rd_cnt           = rd_cnt_q;
    assign wr_cnt           = wr_cnt_q;
    assign dbg_clr_state    = state_q;

endmodule

// File: tb/tb_hash_mem_responder.sv
// Bench for hash_mem_responder: vector table, corner-case sequences and a randomized run
// against an array model of the RAM, counters and flags.
module tb_hash_mem_responder;
    import hash_mem_pkg::*;

    localparam int    DEPTH = 256;
    localparam word_t OOB   = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset, core_en, mem_clk, mem_we;
    logic [15:0] memory_addr;
    logic [31:0] memory_write_data, memory_read_data;
    logic        host_req, host_we, host_ready, host_rvalid;
    logic [15:0] host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        clear, clear_busy, oob_err;
    logic [15:0] rd_cnt, wr_cnt;
    clr_state_t  dbg_clr_state;

    always #5 clk = ~clk;
    assign mem_clk = clk;

    hash_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(16'h0000), .OOB_DATA(OOB)) dut (
        .clk(clk), .reset(reset), .core_en(core_en), .mem_clk(mem_clk), .mem_we(mem_we),
        .memory_addr(memory_addr), .memory_write_data(memory_write_data),
        .memory_read_data(memory_read_data), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .clear(clear),
        .clear_busy(clear_busy), .oob_err(oob_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
        .dbg_clr_state(dbg_clr_state)
    );

    typedef struct {
        logic  we;
        addr_t addr;
        word_t wdata;
        word_t exp_rdata;
        logic  exp_oob;
    } vec_t;

    vec_t  vecs [9];
    word_t model_mem [DEPTH];
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One accepted host access; the caller guarantees core_en=0 and no clear running.
    task automatic host_access(input logic we, input addr_t a, input word_t d, input word_t exp, input string name);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        #1;
        chk({name, "_ready"}, 32'(host_ready), 32'd1);
        tick();
        host_req = 1'b0;
        if (we && a < DEPTH) model_mem[a] = d;
        if (!we) begin
            chk({name, "_rvalid"}, 32'(host_rvalid), 32'd1);
            chk({name, "_rdata"}, host_rdata, exp);
            tick();
            chk({name, "_rvalid_pulse"}, 32'(host_rvalid), 32'd0);
        end
    endtask

    task automatic host_write_q(input addr_t a, input word_t d);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_req = 1'b0;
        if (a < DEPTH) model_mem[a] = d;
    endtask

    task automatic core_cycle(input logic we, input addr_t a, input word_t d);
        core_en = 1'b1; mem_we = we; memory_addr = a; memory_write_data = d;
        tick();
        if (we && a < DEPTH) model_mem[a] = d;
    endtask

    function automatic addr_t rand_addr();
        if ($urandom_range(0, 9) == 0) return 16'($urandom_range(DEPTH, 65535));
        return 16'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        int    cnt;
        logic  h_pending, exp_rv, exp_oob;
        word_t exp_mrd, exp_hrd;
        int    exp_rd, exp_wr;
        logic  zero_ok;

        reset = 1'b1; core_en = 1'b0; mem_we = 1'b0; memory_addr = '0; memory_write_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; clear = 1'b0;

        vecs[0] = '{1'b1, 16'd5,   32'h01234567, 32'h0,          1'b0};
        vecs[1] = '{1'b0, 16'd5,   32'h0,        32'h01234567,   1'b0};
        vecs[2] = '{1'b1, 16'd0,   32'h11111111, 32'h0,          1'b0};
        vecs[3] = '{1'b1, 16'd255, 32'hFFFF0000, 32'h0,          1'b0};
        vecs[4] = '{1'b0, 16'd255, 32'h0,        32'hFFFF0000,   1'b0};
        vecs[5] = '{1'b0, 16'd0,   32'h0,        32'h11111111,   1'b0};
        vecs[6] = '{1'b1, 16'd256, 32'hBAD0BAD0, 32'h0,          1'b1};
        vecs[7] = '{1'b0, 16'd256, 32'h0,        32'hDEADBEEF,   1'b1};
        vecs[8] = '{1'b0, 16'd0,   32'h0,        32'h11111111,   1'b1};

        repeat (2) tick();
        reset = 1'b0;
        chk("rst_mrd", memory_read_data, 32'h0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_hrdata", host_rdata, 32'h0);
        chk("rst_busy", 32'(clear_busy), 32'd0);
        chk("rst_oob", 32'(oob_err), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_state", 32'(dbg_clr_state), 32'(IDLE));

        // Preload, then clear with a 10-cycle core interruption.
        for (int i = 0; i < DEPTH; i++) host_write_q(16'(i), 32'hA000_0000 | 32'(i));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cnt = 0;
        while (clear_busy && cnt < 1000) begin
            cnt++;
            core_en = (cnt >= 50 && cnt < 60);
            clear   = (cnt == 100);
            tick();
        end
        core_en = 1'b0; clear = 1'b0;
        chk("clear_busy_cycles", 32'(cnt), 32'(DEPTH + 10));
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        zero_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            host_req = 1'b1; host_we = 1'b0; host_addr = 16'(i);
            tick();
            host_req = 1'b0;
            if (host_rvalid !== 1'b1 || host_rdata !== 32'h0) zero_ok = 1'b0;
        end
        chk("clear_all_zero", 32'(zero_ok), 32'd1);

        for (int i = 0; i < 9; i++) begin
            host_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_oob", i), 32'(oob_err), 32'(vecs[i].exp_oob));
        end
        do_reset();
        chk("oob_after_reset", 32'(oob_err), 32'd0);

        // Core read-after-write and read-data hold during a write.
        core_cycle(1'b1, 16'd7, 32'hCAFEF00D);
        core_cycle(1'b0, 16'd7, 32'h0);
        chk("raw_mrd", memory_read_data, 32'hCAFEF00D);
        chk("raw_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("raw_rd_cnt", 32'(rd_cnt), 32'd1);
        core_cycle(1'b1, 16'd8, 32'h55AA55AA);
        chk("hold_mrd", memory_read_data, 32'hCAFEF00D);

        // Host blocked while the core owns the RAM.
        core_en = 1'b1; mem_we = 1'b0; memory_addr = 16'd8;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("blocked_ready%0d", i), 32'(host_ready), 32'd0);
            tick();
        end
        chk("core_read_8", memory_read_data, 32'h55AA55AA);
        core_en = 1'b0;
        host_access(1'b0, 16'd7, 32'h0, 32'hCAFEF00D, "unblocked");

        // Out-of-range core access.
        host_access(1'b1, 16'd44, 32'h44444444, 32'h0, "pre44");
        core_cycle(1'b0, 16'd300, 32'h0);
        chk("oob_rd_data", memory_read_data, OOB);
        chk("oob_set", 32'(oob_err), 32'd1);
        core_cycle(1'b1, 16'd300, 32'h13579BDF);
        core_en = 1'b0;
        repeat (3) tick();
        chk("oob_sticky", 32'(oob_err), 32'd1);
        host_access(1'b0, 16'd44, 32'h0, 32'h44444444, "ram_unchanged");
        do_reset();
        chk("oob_cleared", 32'(oob_err), 32'd0);

        // Randomized mix of core and host traffic against the model.
        exp_rv = 1'b0; exp_oob = 1'b0; exp_mrd = '0; exp_hrd = '0; exp_rd = 0; exp_wr = 0;
        h_pending = 1'b0;
        for (int it = 0; it < 1500; it++) begin
            if (!h_pending && $urandom_range(0, 2) == 0) begin
                h_pending = 1'b1; host_req = 1'b1; host_we = 1'($urandom_range(0, 1));
                host_addr = rand_addr(); host_wdata = $urandom();
            end
            core_en = ($urandom_range(0, 2) == 0);
            mem_we = 1'($urandom_range(0, 1)); memory_addr = rand_addr(); memory_write_data = $urandom();
            #1;
            chk("rnd_host_ready", 32'(host_ready), 32'(host_req && !core_en));
            exp_rv = 1'b0;
            if (core_en) begin
                if (memory_addr >= DEPTH) exp_oob = 1'b1;
                if (mem_we) begin
                    if (memory_addr < DEPTH) model_mem[memory_addr] = memory_write_data;
                    if (exp_wr < 65535) exp_wr++;
                end else begin
                    exp_mrd = (memory_addr < DEPTH) ? model_mem[memory_addr] : OOB;
                    if (exp_rd < 65535) exp_rd++;
                end
            end else if (host_req) begin
                if (host_addr >= DEPTH) exp_oob = 1'b1;
                if (host_we) begin
                    if (host_addr < DEPTH) model_mem[host_addr] = host_wdata;
                end else begin
                    exp_rv = 1'b1;
                    exp_hrd = (host_addr < DEPTH) ? model_mem[host_addr] : OOB;
                end
                h_pending = 1'b0;
            end
            tick();
            if (!h_pending) host_req = 1'b0;
            chk("rnd_mrd", memory_read_data, exp_mrd);
            chk("rnd_rvalid", 32'(host_rvalid), 32'(exp_rv));
            chk("rnd_hrdata", host_rdata, exp_hrd);
            chk("rnd_rd_cnt", 32'(rd_cnt), 32'(exp_rd));
            chk("rnd_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
            chk("rnd_oob", 32'(oob_err), 32'(exp_oob));
        end
        host_req = 1'b0; core_en = 1'b0;
        tick();

        // Saturation, then reset in the middle of a clear.
        do_reset();
        host_access(1'b1, 16'd200, 32'hA5A5A5A5, 32'h0, "pre200");
        host_access(1'b1, 16'd2, 32'h12345678, 32'h0, "pre2");
        core_en = 1'b1; mem_we = 1'b0; memory_addr = 16'd1;
        repeat (65540) @(posedge clk);
        #1;
        chk("rd_cnt_sat", 32'(rd_cnt), 32'hFFFF);
        chk("wr_cnt_zero", 32'(wr_cnt), 32'd0);
        core_cycle(1'b1, 16'd3, 32'h33333333);
        chk("rd_cnt_stays", 32'(rd_cnt), 32'hFFFF);
        chk("wr_cnt_one", 32'(wr_cnt), 32'd1);
        core_en = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (4) tick();
        chk("midclear_busy", 32'(clear_busy), 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_busy", 32'(clear_busy), 32'd0);
        chk("abort_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("abort_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("abort_rvalid", 32'(host_rvalid), 32'd0);
        reset = 1'b0;
        host_access(1'b0, 16'd200, 32'h0, 32'hA5A5A5A5, "partial_kept");
        host_access(1'b0, 16'd2, 32'h0, 32'h0, "partial_zeroed");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
